// File: rtl/multdiv_unit.sv
// Iterative multiply (shift-add) / restoring divide unit producing HI/LO plus overflow and divide-by-zero flags.
// Optional signed operation is enabled by defining MULTDIV_SIGNED_EN.
module multdiv_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             mult_ovf,
    output logic             div_zero
);

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    state_t             state, next_state;
    logic [CNT_W-1:0]   count;
    logic [WIDTH-1:0]   operand;
    logic [WIDTH-1:0]   work_hi;
    logic [WIDTH-1:0]   work_lo;
    logic               zero_div;

    logic               accept;
    logic               last;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [WIDTH:0]     sum;
    logic [WIDTH:0]     shifted;
    logic [WIDTH:0]     diff;
    logic               borrow;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quot, rem, dividend;
    logic [WIDTH-1:0]   res_hi, res_lo;
    logic               res_ovf, res_dz;

`ifdef MULTDIV_SIGNED_EN
    logic sign_a, sign_b, is_signed;
    logic in_sign_a, in_sign_b;

    assign in_sign_a = op[1] & a[WIDTH-1];
    assign in_sign_b = op[1] & b[WIDTH-1];
    assign mag_a     = in_sign_a ? -a : a;
    assign mag_b     = in_sign_b ? -b : b;
`else
    logic unused_signed_sel;

    assign unused_signed_sel = op[1];
    assign mag_a             = a;
    assign mag_b             = b;
`endif

    assign accept  = start && (state == IDLE || state == DONE);
    // The cycle after the last iteration (or straight after accept on a zero divisor) writes the result.
    assign last    = (count == CNT_W'(WIDTH)) || zero_div;
    assign busy    = (state == MUL) || (state == DIV);
    assign done    = (state == DONE);

    assign sum     = {1'b0, work_hi} + {1'b0, (work_lo[0] ? operand : {WIDTH{1'b0}})};
    assign shifted = {work_hi, work_lo[WIDTH-1]};
    assign diff    = shifted - {1'b0, operand};
    assign borrow  = diff[WIDTH];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = op[0] ? DIV : MUL;
            MUL,
            DIV:     if (last) next_state = DONE;
            DONE:    next_state = start ? (op[0] ? DIV : MUL) : IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Sign correction and flag generation applied to the raw magnitudes on the result-writing edge.
    always_comb begin
        prod     = {work_hi, work_lo};
        quot     = work_lo;
        rem      = work_hi;
        dividend = work_lo;
`ifdef MULTDIV_SIGNED_EN
        if (sign_a ^ sign_b) begin
            prod = -prod;
            quot = -quot;
        end
        if (sign_a) begin
            rem      = -rem;
            dividend = -dividend;
        end
`endif
        res_ovf = 1'b0;
        res_dz  = 1'b0;
        if (zero_div) begin
            res_hi = dividend;
            res_lo = {WIDTH{1'b1}};
            res_dz = 1'b1;
        end else if (state == DIV) begin
            res_hi = rem;
            res_lo = quot;
        end else begin
            res_hi = prod[2*WIDTH-1:WIDTH];
            res_lo = prod[WIDTH-1:0];
`ifdef MULTDIV_SIGNED_EN
            res_ovf = is_signed ? (res_hi != {WIDTH{res_lo[WIDTH-1]}}) : (res_hi != '0);
`else
            res_ovf = (res_hi != '0);
`endif
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count    <= '0;
            operand  <= '0;
            work_hi  <= '0;
            work_lo  <= '0;
            zero_div <= 1'b0;
            hi       <= '0;
            lo       <= '0;
            mult_ovf <= 1'b0;
            div_zero <= 1'b0;
`ifdef MULTDIV_SIGNED_EN
            sign_a    <= 1'b0;
            sign_b    <= 1'b0;
            is_signed <= 1'b0;
`endif
        end else if (accept) begin
            count    <= '0;
            operand  <= mag_b;
            work_hi  <= '0;
            work_lo  <= mag_a;
            zero_div <= op[0] && (b == '0);
`ifdef MULTDIV_SIGNED_EN
            sign_a    <= in_sign_a;
            sign_b    <= in_sign_b;
            is_signed <= op[1];
`endif
        end else if (busy) begin
            if (last) begin
                hi       <= res_hi;
                lo       <= res_lo;
                mult_ovf <= res_ovf;
                div_zero <= res_dz;
            end else begin
                count <= count + CNT_W'(1);
                if (state == DIV) begin
                    work_hi <= borrow ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
                    work_lo <= {work_lo[WIDTH-2:0], ~borrow};
                end else begin
                    work_hi <= sum[WIDTH:1];
                    work_lo <= {sum[0], work_lo[WIDTH-1:1]};
                end
            end
        end
    end

endmodule

// File: tb/tb_multdiv_unit.sv
// Self-checking bench for multdiv_unit: directed vector table, random ops against an arithmetic model,
// and hand-written sequences for back-to-back issue, ignored start and asynchronous reset.
module tb_multdiv_unit;

    localparam int WIDTH = 32;
`ifdef MULTDIV_SIGNED_EN
    localparam bit SIGNED_EN = 1'b1;
`else
    localparam bit SIGNED_EN = 1'b0;
`endif
    localparam longint MIN32 = -64'sd2147483648;
    localparam longint MAX32 = 64'sd2147483647;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a, b;
    logic             busy, done;
    logic [WIDTH-1:0] hi, lo;
    logic             mult_ovf, div_zero;

    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
        logic        exp_ovf;
        logic        exp_dz;
    } vec_t;

    vec_t vec_list[$];

    multdiv_unit #(.WIDTH(WIDTH), .CNT_W(6)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .op       (op),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .hi       (hi),
        .lo       (lo),
        .mult_ovf (mult_ovf),
        .div_zero (div_zero)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Reference result computed directly from the arithmetic meaning of each op.
    function automatic void model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                                  output logic [31:0] rh, output logic [31:0] rl,
                                  output logic rovf, output logic rdz);
        bit     sgn;
        longint sx, sy, q, r, p;
        sgn  = SIGNED_EN && o[1];
        sx   = sgn ? longint'($signed(x)) : longint'({32'b0, x});
        sy   = sgn ? longint'($signed(y)) : longint'({32'b0, y});
        rovf = 1'b0;
        rdz  = 1'b0;
        if (o[0]) begin
            if (y == 32'd0) begin
                rh  = x;
                rl  = 32'hFFFF_FFFF;
                rdz = 1'b1;
            end else begin
                q  = sx / sy;
                r  = sx % sy;
                rl = q[31:0];
                rh = r[31:0];
            end
        end else begin
            p    = sx * sy;
            rl   = p[31:0];
            rh   = p[63:32];
            rovf = sgn ? (p < MIN32 || p > MAX32) : (rh != 32'd0);
        end
    endfunction

    function automatic int exp_latency(input logic [1:0] o, input logic [31:0] y);
        return (o[0] && y == 32'd0) ? 1 : WIDTH + 1;
    endfunction

    // Drives start for one edge (the accepting edge), then scrambles the inputs.
    task automatic start_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        @(posedge clk);
        #1;
        start = 1'b0;
        a     = $urandom;
        b     = $urandom;
        op    = 2'($urandom_range(0, 3));
    endtask

    task automatic wait_done(input string name, output int lat);
        lat = 0;
        while (done !== 1'b1 && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
            if (busy === 1'b1 && done === 1'b1) check_output({name, " busy&done"}, 64'd1, 64'd0);
        end
        if (lat >= 100) check_output({name, " timeout"}, 64'(lat), 64'd33);
    endtask

    task automatic apply_stimulus(input string name, input logic [1:0] o, input logic [31:0] x,
                                  input logic [31:0] y, input logic [31:0] eh, input logic [31:0] el,
                                  input logic eovf, input logic edz);
        int lat;
        @(negedge clk);
        start_op(o, x, y);
        check_output({name, " busy"}, 64'(busy), 64'd1);
        wait_done(name, lat);
        check_output({name, " latency"}, 64'(lat), 64'(exp_latency(o, y)));
        check_output({name, " hi"}, 64'(hi), 64'(eh));
        check_output({name, " lo"}, 64'(lo), 64'(el));
        check_output({name, " flags"}, {62'd0, mult_ovf, div_zero}, {62'd0, eovf, edz});
        check_output({name, " busy@done"}, 64'(busy), 64'd0);
        @(posedge clk);
        #1;
        check_output({name, " done pulse"}, {62'd0, done, busy}, 64'd0);
        check_output({name, " hold"}, {hi, lo}, {eh, el});
    endtask

    initial begin
        logic [31:0] rh, rl, x, y;
        logic        rovf, rdz;
        logic [1:0]  o;
        int          lat, pulses, first;

        vec_list.push_back('{2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b1, 1'b0});
        vec_list.push_back('{2'b01, 32'd100,       32'd7,         32'd2,         32'd14,        1'b0, 1'b0});
        vec_list.push_back('{2'b01, 32'd5,         32'd0,         32'd5,         32'hFFFF_FFFF, 1'b0, 1'b1});
        vec_list.push_back('{2'b00, 32'd0,         32'hDEAD_BEEF, 32'd0,         32'd0,         1'b0, 1'b0});
        vec_list.push_back('{2'b11, 32'hFFFF_FFF0, 32'd0,         32'hFFFF_FFF0, 32'hFFFF_FFFF, 1'b0, 1'b1});
        vec_list.push_back('{2'b10, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'd0,         1'b1, 1'b0});
`ifdef MULTDIV_SIGNED_EN
        vec_list.push_back('{2'b10, 32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 1'b0});
        vec_list.push_back('{2'b11, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 1'b0});
        vec_list.push_back('{2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000, 1'b0, 1'b0});
        vec_list.push_back('{2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0,         32'd1,         1'b0, 1'b0});
        vec_list.push_back('{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000, 1'b1, 1'b0});
`else
        vec_list.push_back('{2'b10, 32'hFFFF_FFFD, 32'd7,         32'h0000_0006, 32'hFFFF_FFEB, 1'b1, 1'b0});
        vec_list.push_back('{2'b11, 32'hFFFF_FFF9, 32'd2,         32'd1,         32'h7FFF_FFFC, 1'b0, 1'b0});
        vec_list.push_back('{2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0,         1'b0, 1'b0});
        vec_list.push_back('{2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'd1,         1'b1, 1'b0});
`endif

        reset = 1'b0;
        start = 1'b0;
        op    = 2'b00;
        a     = '0;
        b     = '0;
        repeat (3) @(posedge clk);
        #1;
        check_output("reset busy/done", {62'd0, busy, done}, 64'd0);
        check_output("reset hi/lo", {hi, lo}, 64'd0);
        check_output("reset flags", {62'd0, mult_ovf, div_zero}, 64'd0);
        @(negedge clk);
        reset = 1'b1;

        foreach (vec_list[i])
            apply_stimulus($sformatf("vec%0d", i), vec_list[i].op, vec_list[i].a, vec_list[i].b,
                           vec_list[i].exp_hi, vec_list[i].exp_lo, vec_list[i].exp_ovf, vec_list[i].exp_dz);

        // Back-to-back: MULTU issued in the done cycle of a DIVU.
        @(negedge clk);
        start_op(2'b01, 32'd100, 32'd7);
        wait_done("b2b div", lat);
        check_output("b2b div lo/hi", {hi, lo}, {32'd2, 32'd14});
        start_op(2'b00, 32'd6, 32'd7);
        check_output("b2b mul busy", 64'(busy), 64'd1);
        wait_done("b2b mul", lat);
        check_output("b2b mul latency", 64'(lat), 64'd33);
        check_output("b2b mul lo/hi", {hi, lo, 31'd0, mult_ovf}, {32'd0, 32'd42, 32'd0});

        // A start arriving mid-operation must be ignored.
        @(negedge clk);
        start_op(2'b00, 32'd3, 32'd4);
        pulses = 0;
        first  = 0;
        for (int i = 0; i < 45; i++) begin
            if (i == 4) begin
                start = 1'b1;
                a     = 32'd9;
                b     = 32'd9;
            end
            if (i == 5) start = 1'b0;
            @(posedge clk);
            #1;
            if (done === 1'b1) begin
                pulses++;
                if (pulses == 1) first = i + 1;
            end
        end
        check_output("ignored start pulses", 64'(pulses), 64'd1);
        check_output("ignored start latency", 64'(first), 64'd33);
        check_output("ignored start result", {hi, lo}, {32'd0, 32'd12});

        // Asynchronous reset in the middle of a multiply.
        @(negedge clk);
        start_op(2'b00, 32'hFFFF_FFFF, 32'd3);
        repeat (10) @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        check_output("async reset busy/done", {62'd0, busy, done}, 64'd0);
        check_output("async reset hi/lo", {hi, lo}, 64'd0);
        @(negedge clk);
        reset = 1'b1;
        apply_stimulus("post-reset divu", 2'b01, 32'd9, 32'd3, 32'd0, 32'd3, 1'b0, 1'b0);

        // Random operations against the model.
        for (int n = 0; n < 150; n++) begin
            o = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 3))
                0:       x = $urandom_range(0, 255);
                1:       x = 32'h8000_0000 ^ 32'($urandom_range(0, 3));
                default: x = $urandom;
            endcase
            case ($urandom_range(0, 7))
                0:       y = 32'd0;
                1:       y = 32'hFFFF_FFFF;
                2:       y = $urandom_range(1, 15);
                default: y = $urandom;
            endcase
            model(o, x, y, rh, rl, rovf, rdz);
            apply_stimulus($sformatf("rand%0d op%0d", n, o), o, x, y, rh, rl, rovf, rdz);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
